// File: rtl/mtl2_pll_ctrl_pkg.sv
// Shared state encoding and counter constants for the MTL2 display PLL reset sequencer.
package mtl2_pll_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RESET_PLL = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } state_t;

   localparam int CTR_W = 8;
   localparam logic [CTR_W-1:0] CTR_SAT = 8'd255;

endpackage

// File: rtl/mtl2_sync2.sv
// Two-flop synchronizer for a single asynchronous level; async active-high reset to 0.
module mtl2_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mtl2_pll_reset_ctrl.sv
// MTL2 display PLL reset sequencer: pulse PLL reset, qualify lock, release system reset, retry/fault.
// Optional lock-loss counter is built only when MTL2_PLL_CTRL_LOCK_LOSS_CNT_EN is defined.
module mtl2_pll_reset_ctrl
   import mtl2_pll_ctrl_pkg::*;
#(
   parameter int unsigned RST_PULSE_CYC    = 16,
   parameter int unsigned LOCK_STABLE_CYC  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYC = 1048576,
   parameter int unsigned MAX_RETRIES      = 4,
   parameter int unsigned CNT_W            = 21
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             pll_locked,
   input  logic             sw_restart,
   output logic             pll_rst,
   output logic             sys_rst,
   output logic             ready,
   output logic             fault,
   output logic [CTR_W-1:0] retry_cnt,
   output logic [CTR_W-1:0] lock_loss_cnt
);

   localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CTR_W-1:0] RETRY_LIMIT  = CTR_W'(MAX_RETRIES);

   function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
      return (v == CTR_SAT) ? v : v + CTR_W'(1);
   endfunction

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [CTR_W-1:0] retry_nx;
   logic             loss_evt;
   logic             locked_s;

   mtl2_sync2 u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // cnt counts cycles spent in the current state and is cleared on every transition
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      retry_nx = retry_cnt;
      loss_evt = 1'b0;
      if (sw_restart) begin
         state_nx = ST_RESET_PLL;
         cnt_nx   = '0;
         retry_nx = '0;
      end else begin
         case (state)
            ST_RESET_PLL: begin
               cnt_nx = cnt + CNT_W'(1);
               if (cnt == PULSE_LAST) begin
                  state_nx = ST_WAIT_LOCK;
                  cnt_nx   = '0;
               end
            end
            ST_WAIT_LOCK: begin
               cnt_nx = cnt + CNT_W'(1);
               if (locked_s) begin
                  state_nx = ST_STABLE;
                  cnt_nx   = '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  retry_nx = retry_cnt + CTR_W'(1);
                  state_nx = (retry_nx == RETRY_LIMIT) ? ST_FAULT : ST_RESET_PLL;
                  cnt_nx   = '0;
               end
            end
            ST_STABLE: begin
               cnt_nx = cnt + CNT_W'(1);
               if (!locked_s) begin
                  state_nx = ST_WAIT_LOCK;
                  cnt_nx   = '0;
               end else if (cnt == STABLE_LAST) begin
                  state_nx = ST_RUN;
                  cnt_nx   = '0;
                  retry_nx = '0;
               end
            end
            ST_RUN: begin
               if (!locked_s) begin
                  loss_evt = 1'b1;
                  state_nx = ST_RESET_PLL;
                  cnt_nx   = '0;
                  retry_nx = '0;
               end
            end
            ST_FAULT: ;
            default: begin
               state_nx = ST_RESET_PLL;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the state-entry edge
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state     <= ST_RESET_PLL;
         cnt       <= '0;
         retry_cnt <= '0;
         pll_rst   <= 1'b1;
         sys_rst   <= 1'b1;
         ready     <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         retry_cnt <= retry_nx;
         pll_rst   <= (state_nx == ST_RESET_PLL) || (state_nx == ST_FAULT);
         sys_rst   <= (state_nx != ST_RUN);
         ready     <= (state_nx == ST_RUN);
         fault     <= (state_nx == ST_FAULT);
      end
   end

`ifdef MTL2_PLL_CTRL_LOCK_LOSS_CNT_EN
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         lock_loss_cnt <= '0;
      end else if (loss_evt) begin
         lock_loss_cnt <= sat_inc(lock_loss_cnt);
      end
   end
`else
   logic unused_loss;
   assign unused_loss   = loss_evt;
   assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_mtl2_pll_reset_ctrl.sv
// Self-checking bench for mtl2_pll_reset_ctrl with a phase/timer reference model of the sequencer.
module tb_mtl2_pll_reset_ctrl;

   localparam int RP = 4;
   localparam int LS = 8;
   localparam int TO = 32;
   localparam int MR = 2;
`ifdef MTL2_PLL_CTRL_LOCK_LOSS_CNT_EN
   localparam int LOSS_EN = 1;
`else
   localparam int LOSS_EN = 0;
`endif
   localparam int PH_PULSE = 0, PH_WAIT = 1, PH_QUAL = 2, PH_RUN = 3, PH_FAULT = 4;

   typedef struct packed {
      int phase;
      int elapsed;
      int retry;
      int loss;
   } model_t;

   logic       refclk = 1'b0;
   logic       rst = 1'b0;
   logic       pll_locked = 1'b0;
   logic       sw_restart = 1'b0;
   logic       pll_rst, sys_rst, ready, fault;
   logic [7:0] retry_cnt, lock_loss_cnt;
   logic [19:0] dut_vec;
   int         vectors = 0;
   int         miscompares = 0;

   model_t m;
   logic   m_s1, m_s2;

   mtl2_pll_reset_ctrl #(
      .RST_PULSE_CYC(RP), .LOCK_STABLE_CYC(LS), .LOCK_TIMEOUT_CYC(TO),
      .MAX_RETRIES(MR), .CNT_W(21)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .sw_restart(sw_restart),
      .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fault(fault),
      .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
   );

   assign dut_vec = {pll_rst, sys_rst, ready, fault, retry_cnt, lock_loss_cnt};

   always #10 refclk = ~refclk;

   // Reference: elapsed = full cycles completed in the current phase
   function automatic model_t model_next(model_t c, logic ls, logic swr);
      model_t n = c;
      if (swr) begin
         n.phase = PH_PULSE; n.elapsed = 0; n.retry = 0;
         return n;
      end
      case (c.phase)
         PH_PULSE: begin
            n.elapsed = c.elapsed + 1;
            if (n.elapsed == RP) begin n.phase = PH_WAIT; n.elapsed = 0; end
         end
         PH_WAIT: begin
            n.elapsed = c.elapsed + 1;
            if (ls) begin
               n.phase = PH_QUAL; n.elapsed = 0;
            end else if (n.elapsed == TO) begin
               n.retry = c.retry + 1;
               n.phase = (n.retry == MR) ? PH_FAULT : PH_PULSE;
               n.elapsed = 0;
            end
         end
         PH_QUAL: begin
            if (!ls) begin
               n.phase = PH_WAIT; n.elapsed = 0;
            end else begin
               n.elapsed = c.elapsed + 1;
               if (n.elapsed == LS) begin n.phase = PH_RUN; n.elapsed = 0; n.retry = 0; end
            end
         end
         PH_RUN: begin
            if (!ls) begin
               if (LOSS_EN != 0 && c.loss < 255) n.loss = c.loss + 1;
               n.phase = PH_PULSE; n.elapsed = 0; n.retry = 0;
            end
         end
         default: ;
      endcase
      return n;
   endfunction

   function automatic logic [19:0] exp_vec(model_t c);
      return {c.phase == PH_PULSE || c.phase == PH_FAULT, c.phase != PH_RUN,
              c.phase == PH_RUN, c.phase == PH_FAULT, 8'(c.retry), 8'(c.loss)};
   endfunction

   always @(posedge refclk or posedge rst) begin
      if (rst) begin
         m    <= '{phase: PH_PULSE, elapsed: 0, retry: 0, loss: 0};
         m_s1 <= 1'b0;
         m_s2 <= 1'b0;
      end else begin
         m    <= model_next(m, m_s2, sw_restart);
         m_s1 <= pll_locked;
         m_s2 <= m_s1;
      end
   end

   task automatic tick();
      @(negedge refclk);
   endtask

   task automatic do_reset(input logic lock_val);
      rst = 1'b1; sw_restart = 1'b0; pll_locked = lock_val;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic wait_ready(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (ready !== 1'b1 && n < limit);
   endtask

   task automatic reach_run();
      int n;
      do_reset(1'b0);
      n = 0;
      while (pll_rst !== 1'b0 && n < 50) begin tick(); n++; end
      repeat ($urandom_range(0, 10)) tick();
      pll_locked = 1'b1;
      wait_ready(100, n);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      vectors++;
      if (dut_vec !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
         miscompares++;
         $display("FAIL reset_values: got %h want %h", dut_vec, {1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
      end
      rst = 1'b0;
      pll_locked = 1'b1;
      repeat (15) tick();
      vectors++;
      if (ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_run_reached: ready got %b want 1", ready);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (dut_vec !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
         miscompares++;
         $display("FAIL async_reset: got %h want %h", dut_vec, {1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_lock_sequence();
      int n;
      do_reset(1'b0);
      n = 0;
      do begin tick(); n++; end while (pll_rst === 1'b1 && n < 50);
      vectors++;
      if (n !== RP) begin
         miscompares++;
         $display("FAIL pll_rst_width: got %0d cycles want %0d", n, RP);
      end
      repeat (4) tick();
      pll_locked = 1'b1;
      wait_ready(100, n);
      vectors++;
      if (n !== 2 + LS + 1) begin
         miscompares++;
         $display("FAIL ready_latency: got %0d cycles want %0d", n, 2 + LS + 1);
      end
      vectors++;
      if ({sys_rst, fault, retry_cnt} !== 10'd0) begin
         miscompares++;
         $display("FAIL run_outputs: sys_rst=%b fault=%b retry=%0d want 0/0/0", sys_rst, fault, retry_cnt);
      end
      vectors++;
      if (dut_vec !== exp_vec(m)) begin
         miscompares++;
         $display("FAIL lock_seq_model: got %h want %h", dut_vec, exp_vec(m));
      end
   endtask

   task automatic test_timeout();
      logic prev;
      int   len;
      int   runs[$];
      do_reset(1'b0);
      prev = 1'b1;
      len = 0;
      for (int i = 0; i < RP + 2 * TO + RP + 200; i++) begin
         tick();
         vectors++;
         if (dut_vec !== exp_vec(m)) begin
            miscompares++;
            $display("FAIL timeout_model cyc %0d: got %h want %h", i, dut_vec, exp_vec(m));
         end
         if (pll_rst === prev) len++;
         else begin runs.push_back(len); len = 1; prev = pll_rst; end
      end
      runs.push_back(len);
      vectors++;
      if (runs.size() != 5) begin
         miscompares++;
         $display("FAIL timeout_runs: got %0d pll_rst runs want 5", runs.size());
      end else if (runs[1] != TO || runs[2] != RP || runs[3] != TO || runs[4] < 200) begin
         miscompares++;
         $display("FAIL timeout_windows: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/>=200",
                  runs[1], runs[2], runs[3], runs[4], TO, RP, TO);
      end
      vectors++;
      if ({fault, pll_rst, sys_rst, ready, retry_cnt} !== {4'b1110, 8'(MR)}) begin
         miscompares++;
         $display("FAIL fault_state: fault=%b pll_rst=%b sys_rst=%b ready=%b retry=%0d want 1/1/1/0/%0d",
                  fault, pll_rst, sys_rst, ready, retry_cnt, MR);
      end
   endtask

   task automatic test_lock_loss();
      int n, h;
      logic [7:0] loss0;
      reach_run();
      vectors++;
      if (ready !== 1'b1) begin
         miscompares++;
         $display("FAIL loss_reach_run: ready got %b want 1", ready);
      end
      repeat ($urandom_range(1, 6)) tick();
      loss0 = lock_loss_cnt;
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      n = 1;
      while (sys_rst !== 1'b1 && n < 20) begin tick(); n++; end
      vectors++;
      if (n !== 3 || ready !== 1'b0) begin
         miscompares++;
         $display("FAIL loss_latency: got %0d cycles ready=%b want 3 cycles ready=0", n, ready);
      end
      vectors++;
      if (lock_loss_cnt !== 8'(loss0 + LOSS_EN)) begin
         miscompares++;
         $display("FAIL loss_count: got %0d want %0d", lock_loss_cnt, loss0 + LOSS_EN);
      end
      h = 0;
      while (pll_rst === 1'b1 && h < 50) begin h++; tick(); end
      vectors++;
      if (h !== RP) begin
         miscompares++;
         $display("FAIL loss_pulse: got %0d cycles want %0d", h, RP);
      end
      wait_ready(100, n);
      vectors++;
      if (dut_vec !== exp_vec(m) || ready !== 1'b1) begin
         miscompares++;
         $display("FAIL loss_relock: got %h want %h", dut_vec, exp_vec(m));
      end
   endtask

   task automatic test_stable_glitch();
      int n;
      do_reset(1'b0);
      n = 0;
      while (pll_rst !== 1'b0 && n < 50) begin tick(); n++; end
      repeat ($urandom_range(0, 5)) tick();
      pll_locked = 1'b1;
      repeat ($urandom_range(4, 8)) tick();
      vectors++;
      if (ready !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_early_ready: got %b want 0", ready);
      end
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      wait_ready(100, n);
      vectors++;
      if (n !== 2 + LS + 1) begin
         miscompares++;
         $display("FAIL glitch_requalify: got %0d cycles want %0d", n, 2 + LS + 1);
      end
      vectors++;
      if (retry_cnt !== 8'd0 || dut_vec !== exp_vec(m)) begin
         miscompares++;
         $display("FAIL glitch_state: got %h want %h", dut_vec, exp_vec(m));
      end
   endtask

   task automatic test_sw_restart();
      int n, h;
      logic [7:0] loss0;
      do_reset(1'b0);
      n = 0;
      while (fault !== 1'b1 && n < 200) begin tick(); n++; end
      vectors++;
      if (fault !== 1'b1) begin
         miscompares++;
         $display("FAIL restart_fault_reached: fault got %b want 1", fault);
      end
      sw_restart = 1'b1;
      tick();
      sw_restart = 1'b0;
      vectors++;
      if ({fault, retry_cnt, pll_rst, sys_rst} !== {1'b0, 8'd0, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL restart_exit: fault=%b retry=%0d pll_rst=%b sys_rst=%b want 0/0/1/1",
                  fault, retry_cnt, pll_rst, sys_rst);
      end
      h = 0;
      while (pll_rst === 1'b1 && h < 50) begin h++; tick(); end
      vectors++;
      if (h !== RP) begin
         miscompares++;
         $display("FAIL restart_pulse: got %0d cycles want %0d", h, RP);
      end
      repeat ($urandom_range(0, 8)) tick();
      pll_locked = 1'b1;
      wait_ready(100, n);
      vectors++;
      if (ready !== 1'b1 || dut_vec !== exp_vec(m)) begin
         miscompares++;
         $display("FAIL restart_relock: got %h want %h", dut_vec, exp_vec(m));
      end
      loss0 = lock_loss_cnt;
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick();
      sw_restart = 1'b1;
      tick();
      sw_restart = 1'b0;
      vectors++;
      if (lock_loss_cnt !== loss0 || {sys_rst, ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL restart_vs_loss: loss=%0d sys_rst=%b ready=%b want %0d/1/0",
                  lock_loss_cnt, sys_rst, ready, loss0);
      end
   endtask

   task automatic test_saturation();
      int n;
      reach_run();
      for (int i = 0; i < 300; i++) begin
         if (ready !== 1'b1) wait_ready(100, n);
         vectors++;
         if (ready !== 1'b1 || dut_vec !== exp_vec(m)) begin
            miscompares++;
            $display("FAIL sat_iter %0d: got %h want %h", i, dut_vec, exp_vec(m));
            break;
         end
         repeat ($urandom_range(0, 3)) tick();
         pll_locked = 1'b0;
         tick();
         pll_locked = 1'b1;
         repeat (3) tick();
      end
      vectors++;
      if (lock_loss_cnt !== 8'(LOSS_EN * 255)) begin
         miscompares++;
         $display("FAIL loss_saturation: got %0d want %0d", lock_loss_cnt, LOSS_EN * 255);
      end
   endtask

   task automatic test_random();
      do_reset($urandom_range(0, 1) == 1);
      for (int i = 0; i < 3000; i++) begin
         tick();
         vectors++;
         if (dut_vec !== exp_vec(m)) begin
            miscompares++;
            $display("FAIL random cyc %0d: got %h want %h", i, dut_vec, exp_vec(m));
         end
         if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
         sw_restart = ($urandom_range(0, 199) == 0);
      end
      sw_restart = 1'b0;
   endtask

   initial begin
      #5;
      test_reset();
      test_lock_sequence();
      test_timeout();
      test_lock_loss();
      test_stable_glitch();
      test_sw_restart();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
